// File: rtl/dmem_bank_responder.sv
// Load/store responder that serves byte, half-word and word requests from four byte-wide banks.
// Accesses that straddle a word boundary take a second bank beat on the following row.
module dmem_bank_responder #(
   parameter int  DATA_WIDTH     = 32,
   parameter int  DEPTH          = 1024,
   parameter int  NUM_MEM_BLOCKS = 4,
   parameter int  ADDRESS_SPACE  = 4096,
   localparam int AW             = $clog2(ADDRESS_SPACE)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [AW-1:0]         req_addr_i,
   input  logic [1:0]            req_size_i,
   input  logic                  req_we_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_err_o
);

   localparam int RW = AW - 2;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_BEAT0,
      ST_BEAT1,
      ST_LAST,
      ST_RESP
   } state_e;

   state_e                    state_q, state_d;
   logic [AW-1:0]             addr_q, addr_d;
   logic [1:0]                size_q, size_d;
   logic                      we_q, we_d;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic                      err_q, err_d;
   logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;

   logic [1:0]                laneOff;
   logic [2:0]                lastLane;
   logic                      crossWord;
   logic [NUM_MEM_BLOCKS-1:0] beat0Mask, beat1Mask, bankEn, bankWe, captureMask;
   logic [RW-1:0]             rowBase, rowNext, bankRow;
   logic [1:0]                wrSel, rdSel;
   logic [DATA_WIDTH-1:0]     laneWdata;
   logic [DATA_WIDTH-1:0]     bankRdata_q;
   logic [7:0]                mem [NUM_MEM_BLOCKS][DEPTH];

   // Request byte k always sits on bank lane (k + A[1:0]) mod 4, in both beats.
   always_comb begin
      laneOff   = addr_q[1:0];
      rowBase   = addr_q[AW-1:2];
      rowNext   = (rowBase == RW'(DEPTH - 1)) ? '0 : rowBase + 1'b1;
      case (size_q)
         2'd0:    lastLane = {1'b0, laneOff};
         2'd1:    lastLane = {1'b0, laneOff} + 3'd1;
         default: lastLane = {1'b0, laneOff} + 3'd3;
      endcase
      crossWord = lastLane[2];
      wrSel     = '0;
      laneWdata = '0;
      for (int l = 0; l < NUM_MEM_BLOCKS; l++) begin
         beat0Mask[l]         = (3'(l) >= {1'b0, laneOff}) && (3'(l) <= lastLane);
         beat1Mask[l]         = (3'(l) + 3'd4) <= lastLane;
         wrSel                = 2'(l) - laneOff;
         laneWdata[8*l +: 8]  = wdata_q[{wrSel, 3'b000} +: 8];
      end
      bankRow = (state_q == ST_BEAT1) ? rowNext : rowBase;
      case (state_q)
         ST_BEAT0: bankEn = beat0Mask;
         ST_BEAT1: bankEn = beat1Mask;
         default:  bankEn = '0;
      endcase
      bankWe      = bankEn & {NUM_MEM_BLOCKS{we_q}};
      captureMask = '0;
      if (!we_q && !err_q) begin
         if (state_q == ST_BEAT1) begin
            captureMask = beat0Mask;
         end else if (state_q == ST_LAST) begin
            captureMask = crossWord ? beat1Mask : beat0Mask;
         end
      end
   end

   // Bank read data lands one cycle after its beat, so capture trails the bank access by a state.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      size_d  = size_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      rdSel   = '0;
      for (int k = 0; k < NUM_MEM_BLOCKS; k++) begin
         rdSel = 2'(k) + laneOff;
         if (captureMask[rdSel]) begin
            rdata_d[8*k +: 8] = bankRdata_q[{rdSel, 3'b000} +: 8];
         end
      end
      case (state_q)
         ST_INIT: state_d = ST_IDLE;
         ST_IDLE: begin
            if (req_valid_i) begin
               addr_d  = req_addr_i;
               size_d  = req_size_i;
               we_d    = req_we_i;
               wdata_d = req_wdata_i;
               err_d   = (req_size_i == 2'd3);
               rdata_d = '0;
               state_d = (req_size_i == 2'd3) ? ST_LAST : ST_BEAT0;
            end
         end
         ST_BEAT0: state_d = crossWord ? ST_BEAT1 : ST_LAST;
         ST_BEAT1: state_d = ST_LAST;
         ST_LAST:  state_d = ST_RESP;
         ST_RESP: begin
            if (rsp_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_INIT;
         addr_q  <= '0;
         size_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Storage is never reset; each bank has its own enable and a registered read port.
   always_ff @(posedge clk) begin
      for (int b = 0; b < NUM_MEM_BLOCKS; b++) begin
         if (bankEn[b]) begin
            if (bankWe[b]) begin
               mem[b][bankRow] <= laneWdata[8*b +: 8];
            end
            bankRdata_q[8*b +: 8] <= mem[b][bankRow];
         end
      end
   end

   assign req_ready_o = (state_q == ST_IDLE);
   assign rsp_valid_o = (state_q == ST_RESP);
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_bank_responder.sv
// Scoreboard bench for dmem_bank_responder: a byte-array model predicts each response
// and its latency at accept time; responses are popped and compared as they appear.
module tb_dmem_bank_responder;

   logic        clk;
   logic        reset_n;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [11:0] req_addr_i;
   logic [1:0]  req_size_i;
   logic        req_we_i;
   logic [31:0] req_wdata_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } expRsp_t;

   expRsp_t    sbQ[$];
   logic [7:0] model [4096];
   int         checkCount = 0;
   int         errorCount = 0;

   dmem_bank_responder dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_addr_i  (req_addr_i),
      .req_size_i  (req_size_i),
      .req_we_i    (req_we_i),
      .req_wdata_i (req_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [11:0] addr, input logic [1:0] size, input logic we,
                                input logic [31:0] wdata);
      int          waitCycles;
      int          n;
      expRsp_t     e;
      logic [11:0] a;
      waitCycles = 0;
      while (!req_ready_o && waitCycles < 20) begin
         @(posedge clk);
         #1;
         waitCycles++;
      end
      checkOutput("readyBeforeReq", req_ready_o, 1'b1);
      req_addr_i  = addr;
      req_size_i  = size;
      req_we_i    = we;
      req_wdata_i = wdata;
      req_valid_i = 1'b1;
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      n       = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      e.rdata = '0;
      e.err   = (size == 2'd3);
      if (size == 2'd3) begin
         e.lat = 1;
      end else begin
         e.lat = (int'(addr[1:0]) + n > 4) ? 3 : 2;
         for (int k = 0; k < n; k++) begin
            a = addr + 12'(k);
            if (we) model[a] = wdata[8*k +: 8];
            else    e.rdata[8*k +: 8] = model[a];
         end
      end
      sbQ.push_back(e);
   endtask

   task automatic collectResponse(input int holdCycles);
      int      lat;
      expRsp_t e;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!rsp_valid_o && lat < 20);
      checkOutput("rspQueueNonEmpty", (sbQ.size() > 0), 1'b1);
      if (sbQ.size() > 0) e = sbQ.pop_front();
      else                e = '{rdata: '0, err: 1'b0, lat: 0};
      checkOutput("latency", lat, e.lat);
      checkOutput("rdata", rsp_rdata_o, e.rdata);
      checkOutput("err", rsp_err_o, e.err);
      for (int c = 0; c < holdCycles; c++) begin
         req_valid_i = 1'b1;
         req_addr_i  = 12'($urandom);
         req_size_i  = 2'd2;
         req_we_i    = 1'b1;
         req_wdata_i = $urandom;
         @(posedge clk);
         #1;
         checkOutput("holdValid", rsp_valid_o, 1'b1);
         checkOutput("holdRdata", rsp_rdata_o, e.rdata);
         checkOutput("holdErr", rsp_err_o, e.err);
         checkOutput("holdReady", req_ready_o, 1'b0);
      end
      rsp_ready_i = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready_i = 1'b0;
      req_valid_i = 1'b0;
      checkOutput("rspDone", rsp_valid_o, 1'b0);
      checkOutput("readyAfterRsp", req_ready_o, 1'b1);
   endtask

   task automatic doTxn(input logic [11:0] addr, input logic [1:0] size, input logic we,
                        input logic [31:0] wdata);
      applyStimulus(addr, size, we, wdata);
      collectResponse(0);
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [11:0] rAddr;
      logic [1:0]  rSize;
      reset_n     = 1'b0;
      req_valid_i = 1'b0;
      req_addr_i  = '0;
      req_size_i  = '0;
      req_we_i    = 1'b0;
      req_wdata_i = '0;
      rsp_ready_i = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("resetReady", req_ready_o, 1'b0);
      checkOutput("resetValid", rsp_valid_o, 1'b0);
      checkOutput("resetRdata", rsp_rdata_o, 32'h0);
      checkOutput("resetErr", rsp_err_o, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checkOutput("readyBeforeFirstEdge", req_ready_o, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("readyAfterFirstEdge", req_ready_o, 1'b1);

      $display("[TB] directed word, byte and crossing accesses");
      doTxn(12'h0FC, 2'd2, 1'b1, 32'h0000_0000);
      doTxn(12'h100, 2'd2, 1'b1, 32'hDEAD_BEEF);
      doTxn(12'h100, 2'd2, 1'b0, 32'h0);
      doTxn(12'h103, 2'd0, 1'b1, 32'h0000_00A5);
      doTxn(12'h100, 2'd2, 1'b0, 32'h0);
      doTxn(12'h103, 2'd0, 1'b0, 32'h0);
      doTxn(12'h0FF, 2'd1, 1'b1, 32'h0000_1234);
      doTxn(12'h0FC, 2'd2, 1'b0, 32'h0);
      doTxn(12'h100, 2'd0, 1'b0, 32'h0);

      for (int i = 0; i < 8; i++) begin
         doTxn(12'(4 * i), 2'd2, 1'b1, 32'h0);
         doTxn(12'(12'hFE0 + 4 * i), 2'd2, 1'b1, 32'h0);
      end

      $display("[TB] row wrap at top of address space");
      doTxn(12'hFFE, 2'd0, 1'b1, 32'h11);
      doTxn(12'hFFF, 2'd0, 1'b1, 32'h22);
      doTxn(12'h000, 2'd0, 1'b1, 32'h33);
      doTxn(12'h001, 2'd0, 1'b1, 32'h44);
      doTxn(12'hFFE, 2'd2, 1'b0, 32'h0);
      doTxn(12'hFFF, 2'd1, 1'b1, 32'hBEEF_CAFE);
      doTxn(12'hFFC, 2'd2, 1'b0, 32'h0);
      doTxn(12'h000, 2'd2, 1'b0, 32'h0);

      $display("[TB] illegal size");
      doTxn(12'h100, 2'd3, 1'b1, 32'hFFFF_FFFF);
      doTxn(12'h100, 2'd2, 1'b0, 32'h0);

      $display("[TB] response backpressure");
      applyStimulus(12'h0FD, 2'd2, 1'b0, 32'h0);
      collectResponse(5);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("noSecondAccept", rsp_valid_o, 1'b0);

      $display("[TB] reset during first beat");
      applyStimulus(12'h100, 2'd2, 1'b0, 32'h0);
      reset_n = 1'b0;
      void'(sbQ.pop_back());
      #2;
      checkOutput("midResetValid", rsp_valid_o, 1'b0);
      checkOutput("midResetRdata", rsp_rdata_o, 32'h0);
      checkOutput("midResetErr", rsp_err_o, 1'b0);
      checkOutput("midResetReady", req_ready_o, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checkOutput("releaseReadyLow", req_ready_o, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("releaseReadyHigh", req_ready_o, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("noRspAfterReset", rsp_valid_o, 1'b0);
      doTxn(12'h100, 2'd2, 1'b0, 32'h0);

      $display("[TB] random traffic over initialised regions");
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 1) rAddr = 12'($urandom_range(0, 28));
         else                           rAddr = 12'(12'hFE0 + $urandom_range(0, 31));
         if ($urandom_range(0, 7) == 0) rSize = 2'd3;
         else                           rSize = 2'($urandom_range(0, 2));
         doTxn(rAddr, rSize, 1'($urandom_range(0, 1)), $urandom);
      end

      checkOutput("scoreboardEmpty", sbQ.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
